ddc_tune_ctrl: RTL

- Sequencing controller for the DDC receive chain (NCO -> mixer -> CIC -> FIR -> decimate-by-2 -> packed 32-bit I/Q).
- Owns the NCO phase-increment word and holds the chain in reset after power-up and after every retune.
- After reset it blanks the transient output samples for a fixed count, then passes packed I/Q words downstream.
- Sits between the tuning source (register file / host command) and the chain. It consumes the chain's 32-bit data/valid output and forwards it downstream.

---
 rtl/ddc_tune_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ddc_tune_ctrl.sv
// ---------------------------------------------------------------------------
// ddc_tune_ctrl
//
// Sequencing controller for the DDC receive chain. It owns the NCO phase
// increment. It holds the chain in reset after power-up and after every
// retune. It then discards the transient output samples of the chain. After
// that it forwards the packed I/Q words downstream with one clock of latency.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   tune_req   in   1   retune request (level, held until tune_ack)
//   tune_freq  in  32   new phase increment, sampled on acceptance
//   tune_ack   out  1   one-cycle acceptance pulse
//   phi_inc    out 32   NCO phase increment
//   chain_rst  out  1   active-high reset to the DSP chain
//   dsp_data   in  32   packed {I[15:0],Q[15:0]} from the chain
//   dsp_valid  in   1   chain output strobe
//   out_data   out 32   gated data downstream
//   out_valid  out  1   gated strobe downstream
//   busy       out  1   high while flushing or settling
//   tmo_err    out  1   sticky: last settle phase ended by timeout
//
// Optional build macro DDC_TUNE_STATS_EN adds these ports:
//   tune_cnt   out 16   count of accepted retunes, wraps
//   drop_cnt   out 16   count of discarded samples, saturates
// ---------------------------------------------------------------------------
module ddc_tune_ctrl #(
    parameter logic [31:0] FREQ_DEFAULT = 32'h5000_0000,
    parameter int          FLUSH_CYC    = 16,
    parameter int          SETTLE_SMP   = 64,
    parameter int          TIMEOUT_CYC  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tune_req,
    input  logic [31:0] tune_freq,
    output logic        tune_ack,
    output logic [31:0] phi_inc,
    output logic        chain_rst,
    input  logic [31:0] dsp_data,
    input  logic        dsp_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        busy,
    output logic        tmo_err
`ifdef DDC_TUNE_STATS_EN
    ,
    output logic [15:0] tune_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int FW = $clog2(FLUSH_CYC) + 1;
    localparam int SW = $clog2(SETTLE_SMP) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [SW-1:0] SMP_LAST   = SW'((SETTLE_SMP > 0) ? SETTLE_SMP - 1 : 0);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] FLUSH_INC  = FW'(1);
    localparam logic [SW-1:0] SMP_INC    = SW'(1);
    localparam logic [TW-1:0] TMO_INC    = TW'(1);

    // With no samples to discard, the flush goes straight to RUN.
    localparam bit SKIP_SETTLE = (SETTLE_SMP == 0);

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'b00,
        ST_SETTLE = 2'b01,
        ST_RUN    = 2'b10
    } state_t;

    state_t        state_r;
    logic [FW-1:0] flush_cnt_r;
    logic [SW-1:0] smp_cnt_r;
    logic [TW-1:0] cyc_cnt_r;

    logic accept_s;
    logic flush_done_s;
    logic smp_done_s;
    logic tmo_hit_s;

    // Decode the acceptance and phase-completion events for the current cycle.
    always_comb begin
        accept_s     = tune_req && (state_r != ST_FLUSH);
        flush_done_s = (state_r == ST_FLUSH) && (flush_cnt_r == FLUSH_LAST);
        smp_done_s   = (state_r == ST_SETTLE) && dsp_valid && (smp_cnt_r == SMP_LAST);
        tmo_hit_s    = (state_r == ST_SETTLE) && (cyc_cnt_r == TMO_LAST);
    end

    // Sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= {FW{1'b0}};
            smp_cnt_r   <= {SW{1'b0}};
            cyc_cnt_r   <= {TW{1'b0}};
            phi_inc     <= FREQ_DEFAULT;
            chain_rst   <= 1'b1;
            busy        <= 1'b1;
            tune_ack    <= 1'b0;
            out_data    <= 32'h0000_0000;
            out_valid   <= 1'b0;
            tmo_err     <= 1'b0;
        end else if (accept_s) begin
            // A retune takes priority over any settle exit in the same cycle.
            // Any sample that arrives in this cycle is dropped.
            state_r     <= ST_FLUSH;
            flush_cnt_r <= {FW{1'b0}};
            smp_cnt_r   <= {SW{1'b0}};
            cyc_cnt_r   <= {TW{1'b0}};
            phi_inc     <= tune_freq;
            chain_rst   <= 1'b1;
            busy        <= 1'b1;
            tune_ack    <= 1'b1;
            out_valid   <= 1'b0;
            tmo_err     <= 1'b0;
        end else begin
            tune_ack <= 1'b0;
            case (state_r)
                ST_FLUSH: begin
                    out_valid <= 1'b0;
                    if (flush_done_s) begin
                        flush_cnt_r <= {FW{1'b0}};
                        smp_cnt_r   <= {SW{1'b0}};
                        cyc_cnt_r   <= {TW{1'b0}};
                        chain_rst   <= 1'b0;
                        if (SKIP_SETTLE) begin
                            state_r <= ST_RUN;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= ST_SETTLE;
                            busy    <= 1'b1;
                        end
                    end else begin
                        flush_cnt_r <= flush_cnt_r + FLUSH_INC;
                    end
                end
                ST_SETTLE: begin
                    out_valid <= 1'b0;
                    if (smp_done_s) begin
                        // The normal exit wins over a timeout in the same cycle.
                        state_r   <= ST_RUN;
                        busy      <= 1'b0;
                        smp_cnt_r <= {SW{1'b0}};
                        cyc_cnt_r <= {TW{1'b0}};
                    end else if (tmo_hit_s) begin
                        state_r   <= ST_RUN;
                        busy      <= 1'b0;
                        tmo_err   <= 1'b1;
                        smp_cnt_r <= {SW{1'b0}};
                        cyc_cnt_r <= {TW{1'b0}};
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + TMO_INC;
                        if (dsp_valid) begin
                            smp_cnt_r <= smp_cnt_r + SMP_INC;
                        end else begin
                            smp_cnt_r <= smp_cnt_r;
                        end
                    end
                end
                ST_RUN: begin
                    out_valid <= dsp_valid;
                    if (dsp_valid) begin
                        out_data <= dsp_data;
                    end else begin
                        out_data <= out_data;
                    end
                end
                default: begin
                    state_r     <= ST_FLUSH;
                    flush_cnt_r <= {FW{1'b0}};
                    smp_cnt_r   <= {SW{1'b0}};
                    cyc_cnt_r   <= {TW{1'b0}};
                    chain_rst   <= 1'b1;
                    busy        <= 1'b1;
                    out_valid   <= 1'b0;
                end
            endcase
        end
    end

`ifdef DDC_TUNE_STATS_EN
    // Statistics counters. They are cleared by rst only and survive retunes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tune_cnt <= 16'h0000;
            drop_cnt <= 16'h0000;
        end else begin
            if (accept_s) begin
                tune_cnt <= tune_cnt + 16'h0001;
            end else begin
                tune_cnt <= tune_cnt;
            end
            if (dsp_valid && ((state_r != ST_RUN) || accept_s) && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'h0001;
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end
`endif

endmodule
